// File: rtl/zle_arb2_pkg.sv
// Shared definitions for the two-stream zero run-length encoder arbiter:
// owner encoding, FSM state constants, code format and tag layout.
package zle_arb2_pkg;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int unsigned RUN_FLAG_BIT = 3;
  localparam int unsigned RUN_MAX      = 16;

  // One tag per code-producing token; two=1 means the token yields two codes.
  typedef struct packed {
    logic owner;
    logic two;
  } tag_t;

  // Number of codes the encoder will emit for accepting tok with zcnt zeros pending.
  function automatic logic [1:0] codes_for(input logic [2:0] tok, input logic [4:0] zcnt);
    if (tok != 3'd0) return (zcnt != 5'd0) ? 2'd2 : 2'd1;
    return (zcnt == 5'(RUN_MAX - 1)) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/zle_arb2_tagfifo.sv
// Owner-tag FIFO: each entry routes one or two encoder codes to their stream.
// "take" consumes one code from the head entry, popping it once exhausted.
module zle_arb2_tagfifo
  import zle_arb2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  tag_t push_tag,
  input  logic take,
  output logic head_owner,
  output logic empty,
  output logic full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          dec;
  logic          do_push;

  always_comb begin
    empty      = (count == '0);
    full       = (count == (AW+1)'(DEPTH));
    head_owner = mem[rd_ptr].owner;
    pop        = take && !empty && !mem[rd_ptr].two;
    dec        = take && !empty && mem[rd_ptr].two;
    // A pop frees the head slot first, so a push is legal even when full.
    do_push    = push && (!full || pop);
  end

  always_ff @(posedge clock) begin
    if (dec)     mem[rd_ptr].two <= 1'b0;
    if (do_push) mem[wr_ptr]     <= push_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zle_arb2.sv
// Two-requester arbiter sharing one zero run-length encoder between streams A and B.
// Ownership changes only when no zero run is pending; output codes are routed by owner tags.
module zle_arb2
  import zle_arb2_pkg::*;
#(
  parameter int unsigned BURST    = 8,
  parameter int unsigned TAGDEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] a_d,
  input  logic       a_v,
  output logic       a_b,
  input  logic [2:0] b_d,
  input  logic       b_v,
  output logic       b_b,
  output logic [2:0] e_i_d,
  output logic       e_i_v,
  input  logic       e_i_b,
  input  logic [3:0] e_o_d,
  input  logic       e_o_v,
  output logic       e_o_b,
  output logic [3:0] oa_d,
  output logic       oa_v,
  input  logic       oa_b,
  output logic [3:0] ob_d,
  output logic       ob_v,
  input  logic       ob_b
);

  localparam logic [7:0] BURST_MAX = 8'(BURST);

  logic [0:0] state;
  logic       owner;
  logic       last_owner;
  logic [4:0] zcnt;
  logic [7:0] bcnt;

  logic       granted;
  logic       own_v;
  logic       oth_v;
  logic [2:0] own_d;
  logic       yield_sw;
  logic       go_idle;
  logic       own_b;
  logic       accept;
  logic [1:0] ncodes;
  logic       tag_push;
  tag_t       push_tag;
  logic [4:0] zcnt_nxt;
  logic       pick;
  logic       tagfull;
  logic       tagempty;
  logic       head_owner;
  logic       take;

  always_comb begin
    granted  = (state == ST_GRANT);
    own_v    = (owner == OWN_A) ? a_v : b_v;
    own_d    = (owner == OWN_A) ? a_d : b_d;
    oth_v    = (owner == OWN_A) ? b_v : a_v;
    // The owner is held off in the switch cycle so no zero can open a run mid-handover.
    yield_sw = granted && (zcnt == '0) && oth_v && ((bcnt == BURST_MAX) || !own_v);
    go_idle  = granted && (zcnt == '0) && !a_v && !b_v;
    e_i_v    = granted && own_v && !tagfull && !yield_sw;
    e_i_d    = granted ? own_d : '0;
    accept   = e_i_v && !e_i_b;
    own_b    = e_i_b || tagfull || yield_sw;
    a_b      = !(granted && (owner == OWN_A)) || own_b;
    b_b      = !(granted && (owner == OWN_B)) || own_b;
    ncodes   = codes_for(own_d, zcnt);
    tag_push = accept && (ncodes != 2'd0);
    push_tag = '{owner: owner, two: (ncodes == 2'd2)};
    zcnt_nxt = ((own_d != 3'd0) || (zcnt == 5'(RUN_MAX - 1))) ? '0 : zcnt + 5'd1;
    pick     = (a_v && b_v) ? !last_owner : (a_v ? OWN_A : OWN_B);
  end

  always_comb begin
    e_o_b = tagempty || ((head_owner == OWN_B) ? ob_b : oa_b);
    oa_v  = e_o_v && !tagempty && (head_owner == OWN_A);
    ob_v  = e_o_v && !tagempty && (head_owner == OWN_B);
    oa_d  = e_o_d;
    ob_d  = e_o_d;
    take  = e_o_v && !e_o_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      zcnt       <= '0;
      bcnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (a_v || b_v) begin
            state      <= ST_GRANT;
            owner      <= pick;
            last_owner <= pick;
            bcnt       <= '0;
          end
        end
        default: begin
          if (accept) begin
            zcnt <= zcnt_nxt;
            if (bcnt != BURST_MAX) bcnt <= bcnt + 8'd1;
          end
          if (yield_sw) begin
            owner      <= !owner;
            last_owner <= !owner;
            bcnt       <= '0;
          end else if (go_idle) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  zle_arb2_tagfifo #(
    .DEPTH(TAGDEPTH)
  ) u_tagfifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tag_push),
    .push_tag  (push_tag),
    .take      (take),
    .head_owner(head_owner),
    .empty     (tagempty),
    .full      (tagfull)
  );

endmodule

// File: tb/tb_zle_arb2.sv
// Bench for zle_arb2: token-level sources, a behavioural ZLE encoder and
// consumer collectors, with table-driven single-owner vectors plus corner sequences.
module tb_zle_arb2;
  import zle_arb2_pkg::*;

  typedef int iq_t[$];
  typedef struct {
    logic [2:0] tok;
    int         n;
    logic [3:0] c0;
    logic [3:0] c1;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] a_d, b_d, e_i_d;
  logic       a_v, a_b, b_v, b_b, e_i_v, e_i_b;
  logic [3:0] e_o_d, oa_d, ob_d;
  logic       e_o_v, e_o_b, oa_v, oa_b, ob_v, ob_b;

  logic [2:0] src_a[$];
  logic [2:0] src_b[$];
  logic [3:0] enc_q[$];
  int         enc_zc;
  iq_t        got_a, got_b, acc_log;
  bit         ob_seen;
  int         n_chk = 0;
  int         n_fail = 0;

  zle_arb2 #(
    .BURST(2),
    .TAGDEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .a_d(a_d), .a_v(a_v), .a_b(a_b),
    .b_d(b_d), .b_v(b_v), .b_b(b_b),
    .e_i_d(e_i_d), .e_i_v(e_i_v), .e_i_b(e_i_b),
    .e_o_d(e_o_d), .e_o_v(e_o_v), .e_o_b(e_o_b),
    .oa_d(oa_d), .oa_v(oa_v), .oa_b(oa_b),
    .ob_d(ob_d), .ob_v(ob_v), .ob_b(ob_b)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_q(input string name, input iq_t g, input iq_t e);
    check({name, "_len"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++)
      check($sformatf("%s[%0d]", name, i), g[i], e[i]);
  endtask

  function automatic logic [3:0] run_code(input int n);
    logic [3:0] c;
    c = 4'(n - 1);
    c[RUN_FLAG_BIT] = 1'b1;
    return c;
  endfunction

  task automatic encode(input logic [2:0] tok);
    if (tok != 3'd0) begin
      if (enc_zc > 0) enc_q.push_back(run_code(enc_zc));
      enc_q.push_back({1'b0, tok});
      enc_zc = 0;
    end else begin
      enc_zc++;
      if (enc_zc == RUN_MAX) begin
        enc_q.push_back(run_code(enc_zc));
        enc_zc = 0;
      end
    end
  endtask

  task automatic drive();
    a_v   = (src_a.size() > 0);
    a_d   = (src_a.size() > 0) ? src_a[0] : 3'd0;
    b_v   = (src_b.size() > 0);
    b_d   = (src_b.size() > 0) ? src_b[0] : 3'd0;
    e_o_v = (enc_q.size() > 0);
    e_o_d = (enc_q.size() > 0) ? enc_q[0] : 4'd0;
  endtask

  // Transfers are sampled at the falling edge and applied just after the rising edge.
  task automatic cycle();
    logic ax, bx, ix, ox, oax, obx;
    logic [2:0] tok;
    logic [3:0] oad, obd;
    @(negedge clock);
    ax  = a_v && !a_b;
    bx  = b_v && !b_b;
    ix  = e_i_v && !e_i_b;
    ox  = e_o_v && !e_o_b;
    oax = oa_v && !oa_b;
    obx = ob_v && !ob_b;
    tok = e_i_d;
    oad = oa_d;
    obd = ob_d;
    if (ob_v) ob_seen = 1'b1;
    @(posedge clock);
    #1;
    if (ax) begin src_a.delete(0); acc_log.push_back(0); end
    if (bx) begin src_b.delete(0); acc_log.push_back(1); end
    if (ox) enc_q.delete(0);
    if (ix) encode(tok);
    if (oax) got_a.push_back(int'(oad));
    if (obx) got_b.push_back(int'(obd));
    drive();
  endtask

  task automatic clear_env();
    src_a.delete();
    src_b.delete();
    enc_q.delete();
    enc_zc = 0;
    got_a.delete();
    got_b.delete();
    acc_log.delete();
    ob_seen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_env();
    drive();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string name, input int max);
    int k;
    k = 0;
    while ((src_a.size() > 0 || src_b.size() > 0 || enc_q.size() > 0) && k < max) begin
      cycle();
      k++;
    end
    check({name, "_done"}, (src_a.size() + src_b.size() + enc_q.size() == 0) ? 1 : 0, 1);
    run(3);
  endtask

  initial begin
    vec_t tv[$];
    iq_t  e;

    reset = 1'b1;
    e_i_b = 1'b0;
    oa_b  = 1'b0;
    ob_b  = 1'b0;
    clear_env();
    drive();
    run(2);
    check("rst_a_b", a_b, 1);
    check("rst_b_b", b_b, 1);
    check("rst_e_i_v", e_i_v, 0);
    check("rst_e_o_b", e_o_b, 1);
    check("rst_oa_v", oa_v, 0);
    check("rst_ob_v", ob_v, 0);
    reset = 1'b0;

    // Single-owner vectors: token, expected code count, expected codes
    tv.push_back('{3'd5, 1, 4'h5, 4'h0});
    tv.push_back('{3'd0, 0, 4'h0, 4'h0});
    tv.push_back('{3'd0, 0, 4'h0, 4'h0});
    tv.push_back('{3'd3, 2, 4'h9, 4'h3});
    tv.push_back('{3'd1, 1, 4'h1, 4'h0});
    tv.push_back('{3'd0, 0, 4'h0, 4'h0});
    tv.push_back('{3'd7, 2, 4'h8, 4'h7});
    for (int i = 0; i < 15; i++) tv.push_back('{3'd0, 0, 4'h0, 4'h0});
    tv.push_back('{3'd0, 1, 4'hF, 4'h0});
    tv.push_back('{3'd0, 0, 4'h0, 4'h0});
    tv.push_back('{3'd2, 2, 4'h8, 4'h2});
    tv.push_back('{3'd6, 1, 4'h6, 4'h0});
    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      got_a.delete();
      src_a.push_back(tv[i].tok);
      drive();
      drain($sformatf("vec%0d", i), 40);
      check($sformatf("vec%0d_n", i), got_a.size(), tv[i].n);
      if (tv[i].n >= 1 && got_a.size() >= 1) check($sformatf("vec%0d_c0", i), got_a[0], int'(tv[i].c0));
      if (tv[i].n == 2 && got_a.size() >= 2) check($sformatf("vec%0d_c1", i), got_a[1], int'(tv[i].c1));
    end
    check("vec_ob_silent", int'(ob_seen), 0);

    // Burst switching with BURST=2
    do_reset();
    for (int i = 1; i <= 6; i++) src_a.push_back(3'(i));
    for (int i = 7; i >= 2; i--) src_b.push_back(3'(i));
    drive();
    drain("burst", 100);
    e = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    check_q("burst_order", acc_log, e);
    e = '{1, 2, 3, 4, 5, 6};
    check_q("burst_oa", got_a, e);
    e = '{7, 6, 5, 4, 3, 2};
    check_q("burst_ob", got_b, e);

    // Run safety: owner A idles mid-run while B requests
    do_reset();
    src_a.push_back(3'd0);
    src_a.push_back(3'd0);
    src_b.push_back(3'd1);
    drive();
    run(14);
    check("safe_b_stalled", b_b, 1);
    check("safe_a_count", acc_log.size(), 2);
    src_a.push_back(3'd7);
    drive();
    drain("safe", 40);
    e = '{0, 0, 0, 1};
    check_q("safe_order", acc_log, e);
    e = '{9, 7};
    check_q("safe_oa", got_a, e);
    e = '{1};
    check_q("safe_ob", got_b, e);

    // Max run of 16 zeros closes the run and allows an immediate switch
    do_reset();
    for (int i = 0; i < 16; i++) src_a.push_back(3'd0);
    src_b.push_back(3'd4);
    drive();
    drain("maxrun", 80);
    check("maxrun_len", acc_log.size(), 17);
    if (acc_log.size() == 17) check("maxrun_b_last", acc_log[16], 1);
    e = '{15};
    check_q("maxrun_oa", got_a, e);
    e = '{4};
    check_q("maxrun_ob", got_b, e);

    // Consumer backpressure fills the tag FIFO
    do_reset();
    oa_b = 1'b1;
    for (int i = 1; i <= 5; i++) src_a.push_back(3'(i));
    drive();
    run(15);
    check("bp_accepted", acc_log.size(), 4);
    check("bp_a_b", a_b, 1);
    check("bp_e_i_v", e_i_v, 0);
    check("bp_e_o_b", e_o_b, 1);
    oa_b = 1'b0;
    drive();
    drain("bp", 60);
    e = '{1, 2, 3, 4, 5};
    check_q("bp_oa", got_a, e);

    // Encoder input backpressure
    do_reset();
    e_i_b = 1'b1;
    src_a.push_back(3'd6);
    drive();
    run(6);
    check("eib_accepted", acc_log.size(), 0);
    check("eib_a_b", a_b, 1);
    check("eib_e_i_v", e_i_v, 1);
    e_i_b = 1'b0;
    drive();
    drain("eib", 20);
    e = '{6};
    check_q("eib_oa", got_a, e);

    // Reset mid-run
    do_reset();
    src_a.push_back(3'd0);
    src_a.push_back(3'd0);
    drive();
    run(6);
    check("mid_pre_count", acc_log.size(), 2);
    reset = 1'b1;
    clear_env();
    drive();
    cycle();
    check("mid_a_b", a_b, 1);
    check("mid_b_b", b_b, 1);
    check("mid_e_i_v", e_i_v, 0);
    check("mid_e_o_b", e_o_b, 1);
    check("mid_oa_v", oa_v, 0);
    check("mid_ob_v", ob_v, 0);
    src_a.push_back(3'd1);
    src_b.push_back(3'd2);
    drive();
    reset = 1'b0;
    drain("mid", 40);
    e = '{0, 1};
    check_q("mid_order", acc_log, e);
    e = '{1};
    check_q("mid_oa", got_a, e);
    e = '{2};
    check_q("mid_ob", got_b, e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/zle_arb2.md
# zle_arb2

Two-requester arbiter that time-shares one zero run-length encoder (3-bit tokens in, 4-bit codes out) between stream A and stream B. It sits between the two producer streams and the encoder input, and between the encoder output and the two consumer streams. Ownership switches only at code boundaries, so no zero run ever mixes tokens from both requesters. The block predicts how many codes each accepted token will produce and uses an owner-tag FIFO to route every encoder output code back to the stream that produced it.

## Interface
- BURST, 8: maximum tokens accepted from one owner before it must yield at the next safe boundary (1..255).
- TAGDEPTH, 4: owner-tag FIFO entries (power of 2, ≥2).
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- a_d  in  3  stream A token; a_v in 1 valid; a_b out 1 backpressure (1 = stall).
- b_d  in  3  stream B token; b_v in 1 valid; b_b out 1 backpressure (1 = stall).
- e_i_d  out  3  token to encoder; e_i_v out 1; e_i_b in 1 encoder input backpressure.
- e_o_d  in  4  code from encoder; e_o_v in 1; e_o_b out 1 backpressure to encoder output.
- oa_d  out  4  code to consumer A; oa_v out 1; oa_b in 1.
- ob_d  out  4  code to consumer B; ob_v out 1; ob_b in 1.

## Operation
- Transfer on any stream: v=1 and b=0 in the same cycle.
- Encoder behaviour:
  - A nonzero token t produces code {0,t}.
  - A zero run of length n (1..16) produces code {1,n-1}.
  - A run is emitted when a nonzero token ends it, or immediately when the 16th consecutive zero is accepted.
- zcnt (5 bits) tracks consecutive zeros accepted from the current owner. It resets to 0 on a nonzero token and on reaching 16.
- Safe boundary: zcnt==0.
- Codes per accepted token:
  - Nonzero token with zcnt>0: 2 codes.
  - Nonzero token with zcnt==0: 1 code.
  - Zero token that makes zcnt 16: 1 code.
  - Any other zero token: 0 codes.
- Tag FIFO entry is {owner, n∈{1,2}}. One entry is pushed per accepted token that produces ≥1 code.
- Input acceptance:
  - Only the owner's token is forwarded: e_i_d/e_i_v mux from owner.
  - Owner's b = e_i_b OR tagfull. The non-owner's b = 1.
  - Token accepted iff owner v, !e_i_b, !tagfull.
- FSM states:
  - IDLE: no owner.
  - GRANT: owner reg valid, plus burst counter bcnt.
- Transitions:
  - IDLE→GRANT: pick a requester with v=1. On a tie, pick the side opposite last_owner (reset last_owner=B, so A wins first).
  - GRANT→GRANT(other): at a safe boundary, when (bcnt==BURST or owner v=0) and the other v=1. bcnt clears on the switch.
  - GRANT→IDLE: at a safe boundary when neither requester has v=1.
  - Owner v=0 with zcnt>0: grant holds indefinitely, by design. Producers must complete runs.
- Output routing:
  - Head tag selects the consumer. e_o_b = selected consumer's b, or 1 if the FIFO is empty.
  - On each e_o transfer, decrement head n. Pop the entry when n reaches 0.
  - Unselected consumer v=0.
- Same-cycle push and pop on the tag FIFO is allowed, including when full: it pops first, then pushes.

## Timing
- Input path is combinational: a/b to e_i, e_i_b to a_b/b_b. Output path is combinational: e_o to oa/ob. No added latency.
- Ownership switch takes effect the cycle after the boundary condition is registered. A 1-cycle grant bubble on a switch is allowed.
- Reset values:
  - State IDLE; zcnt=0; bcnt=0; FIFO empty.
  - a_b=b_b=1, e_i_v=0, e_o_b=1, oa_v=ob_v=0.
- Reset mid-run discards pending tags. The encoder must be reset by the same reset.
- Boundaries:
  - Empty FIFO: e_o_b=1.
  - Full FIFO: input stalled, even for zero tokens.
  - Pointer wrap modulo TAGDEPTH.
  - bcnt saturates at BURST.

## Structure
- Shared package: owner encoding (A=0, B=1), FSM state constants, code-format constants (run flag bit 3, run max 16).
- One natural sub-module: zle_arb2_tagfifo (sync FIFO, width 2, with head-decrement port).

## Test plan
- Single owner: A sends 5,0,0,3 → oa gets 4'h5, 4'h9, 4'h3 in order; ob_v never 1.
- Burst switch: A and B both send nonzero streams with BURST=2. Grants run A,A,B,B,A…; each consumer receives only its own codes, in order.
- Run safety: A sends 0,0 then drops a_v while b_v=1. B stays stalled until A sends 7; then oa gets 4'h9, 4'h7, and B is granted.
- Max run: A sends 16 zeros → single code 4'hF to oa. A switch to B is permitted immediately after.
- Backpressure: hold oa_b=1 while A sends 1,2,3,4,5. Input stalls once TAGDEPTH=4 tags are pending; on release all five codes arrive, none lost or duplicated.
- Reset mid-run: reset asserted after A sends 0,0 → next cycle all outputs are at reset values, FIFO is empty, and the next grant goes to A on a tie.
